// File: rtl/parallel_adder.sv
// Registered WIDTH-bit ripple-carry adder: sum/cout = a + b + cin.
// The result is captured one cycle after an accepted in_valid, together with
// signed-overflow and zero flags, so downstream stages can use them directly.
// Outputs hold their last captured value while in_valid is low.
module parallel_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // Full-adder carry out: generate, or propagate an incoming carry.
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (c & (x ^ y));
  endfunction

  // Two's-complement overflow: carry into the MSB differs from carry out of it.
  function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

  // ---- stage p0: combinational ripple chain ----
  logic [WIDTH:0]   carry_p0;
  logic [WIDTH-1:0] sum_p0;
  logic             ovf_p0;
  logic             zero_p0;

  assign carry_p0[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum_p0[i]        = fa_sum(a[i], b[i], carry_p0[i]);
    assign carry_p0[i + 1]  = fa_carry(a[i], b[i], carry_p0[i]);
  end

  // For WIDTH=1 the carry into the MSB is cin itself, which carry_p0[0] holds.
  assign ovf_p0  = signed_ovf(carry_p0[WIDTH-1], carry_p0[WIDTH]);
  assign zero_p0 = ~|sum_p0;

  // ---- stage p1: output registers ----
  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;
  logic             ovf_p1;
  logic             zero_p1;
  logic             vld_p1;

  // Capture the result on accepted input; hold otherwise; reset clears all.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
      zero_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1  <= sum_p0;
        cout_p1 <= carry_p0[WIDTH];
        ovf_p1  <= ovf_p0;
        zero_p1 <= zero_p0;
      end
    end
  end

  assign sum       = sum_p1;
  assign cout      = cout_p1;
  assign overflow  = ovf_p1;
  assign zero      = zero_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_parallel_adder.sv
// Bench for parallel_adder (WIDTH=4): hand-computed vector table, streaming,
// hold, mid-stream reset and an exhaustive sweep against a behavioural model.
module tb_parallel_adder;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         in_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         zero;
  logic         out_valid;

  parallel_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t sb_q[$];
  vec_t held;
  int   next_kind;   // 0 = hold, 1 = new result, 2 = reset

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    vec_t r;
    logic [W:0] t;
    t     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.a   = x;
    r.b   = y;
    r.cin = c;
    r.s   = t[W-1:0];
    r.co  = t[W];
    r.ov  = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
    r.z   = (r.s == '0);
    return r;
  endfunction

  task automatic check_outputs();
    vec_t e;
    case (next_kind)
      2: begin
        cmp("rst_valid", out_valid, 0);
        e = '{a: '0, b: '0, cin: 0, s: '0, co: 0, ov: 0, z: 0};
        held = e;
      end
      1: begin
        cmp("valid", out_valid, 1);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_empty at %0t: got no expectation, expected one", $time);
          e = held;
        end else begin
          e = sb_q.pop_front();
        end
        held = e;
      end
      default: begin
        cmp("hold_valid", out_valid, 0);
        e = held;
      end
    endcase
    cmp("sum", sum, e.s);
    cmp("cout", cout, e.co);
    cmp("overflow", overflow, e.ov);
    cmp("zero", zero, e.z);
  endtask

  // One cycle: check what the previous edge produced, then drive new inputs.
  task automatic step(input logic r, input logic v, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic c, input vec_t exp);
    @(negedge clk);
    check_outputs();
    rst = r; in_valid = v; a = x; b = y; cin = c;
    if (r) begin
      sb_q.delete();
      next_kind = 2;
    end else if (v) begin
      sb_q.push_back(exp);
      next_kind = 1;
    end else begin
      next_kind = 0;
    end
  endtask

  task automatic apply(input vec_t v);
    step(1'b0, 1'b1, v.a, v.b, v.cin, v);
  endtask

  task automatic idle();
    vec_t d;
    d = '{a: '0, b: '0, cin: 0, s: '0, co: 0, ov: 0, z: 0};
    step(1'b0, 1'b0, 4'hA, 4'h3, 1'b1, d);
  endtask

  task automatic reset_cycle();
    vec_t d;
    d = '{a: '0, b: '0, cin: 0, s: '0, co: 0, ov: 0, z: 0};
    step(1'b1, 1'b1, 4'h9, 4'h6, 1'b1, d);
  endtask

  vec_t tbl[7];
  vec_t m;

  initial begin
    //        a        b        cin   sum      cout  ovf   zero
    tbl[0] = '{4'b1011, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{4'b1000, 4'b1011, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{4'b0111, 4'b1101, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0};

    // Reset held for two cycles with valid, nonzero inputs.
    rst = 1'b1; in_valid = 1'b1; a = 4'hC; b = 4'h7; cin = 1'b1;
    next_kind = 2;
    held = '{a: '0, b: '0, cin: 0, s: '0, co: 0, ov: 0, z: 0};
    reset_cycle();
    reset_cycle();

    // Table vectors, each isolated by an idle cycle (exercises hold).
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i]);
      idle();
    end

    // Streaming vectors 2,3,4 back to back, then drop valid and hold 0101.
    apply(tbl[0]);
    apply(tbl[1]);
    apply(tbl[2]);
    idle();
    idle();
    idle();

    // Full table streamed with no bubbles.
    for (int i = 0; i < 7; i++) apply(tbl[i]);

    // Mid-stream reset clears everything on the next edge.
    apply(tbl[1]);
    apply(tbl[3]);
    reset_cycle();
    apply(tbl[2]);
    idle();

    // Exhaustive sweep with occasional bubbles.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] idx;
      idx = i[8:0];
      m = model(idx[3:0], idx[7:4], idx[8]);
      apply(m);
      if (i % 37 == 36) idle();
    end
    idle();
    idle();

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending results, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parallel_adder.md
Name: parallel_adder

Overview:
- Registered WIDTH-bit parallel adder: computes a + b + cin through a chain of full-adder cells and registers the result on the clock.
- Used as the basic add stage in datapath blocks; default configuration is 4-bit.
- Also provides a valid strobe and status flags (signed overflow, zero) so downstream logic can consume results without recomputing them.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B, unsigned or two's complement.
- cin  input  1  carry into bit 0.
- in_valid  input  1  qualifies a/b/cin for capture this cycle.
- sum  output  WIDTH  registered low WIDTH bits of a+b+cin.
- cout  output  1  registered carry out of the MSB.
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  registered flag, 1 when sum == 0.
- out_valid  output  1  registered; high one cycle after an accepted in_valid.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, sum=0, cout=0, overflow=0, zero=0, out_valid=0. Reset overrides in_valid in the same cycle.
- Datapath:
  - Combinational ripple of WIDTH full-adder cells. Cell i computes s_i = a_i ^ b_i ^ c_i and c_(i+1) = a_i&b_i | c_i&(a_i^b_i), with c_0 = cin.
  - The full {cout,sum} equals a + b + cin exactly, treated as an unsigned (WIDTH+1)-bit result. No saturation.
- Latency: exactly one cycle. With in_valid=1 at edge N, sum, cout, overflow and zero reflect those inputs after edge N, and out_valid=1.
- Hold: when in_valid=0 (and rst=0), sum, cout, overflow and zero keep their previous values, and out_valid=0 on the next edge.
- Back-to-back: in_valid may stay high every cycle. Each cycle's inputs produce a result one cycle later, with no bubbles.
- Wrap-around: all-ones + all-ones + 1 gives sum = all-ones and cout=1. All-ones + 0 + 1 gives sum=0, cout=1, zero=1.
- Flags:
  - overflow uses only the two's-complement interpretation.
  - zero ignores cout.
- X handling: none required. Inputs are sampled only when in_valid=1.
- No backpressure. There is no ready signal, and the block always accepts input.

Test Plan:
1. Reset: assert rst for 2 cycles with in_valid=1 and nonzero inputs -> sum=0000, cout=0, overflow=0, zero=0, out_valid=0.
2. a=1011, b=0101, cin=0, in_valid=1 -> next cycle sum=0000, cout=1, zero=1, overflow=0, out_valid=1.
3. a=1000, b=1011, cin=1 -> sum=0100, cout=1, overflow=1 (-8 + -5 + 1 = -12 does not fit in 4-bit signed), zero=0.
4. a=0111, b=1101, cin=1 -> sum=0101, cout=1, overflow=0, zero=0.
5. Streaming and hold: apply vectors 2, 3 and 4 on consecutive cycles, then drop in_valid.
   - Results appear in order, one per cycle.
   - After in_valid drops, out_valid goes low and sum=0101 is held.
   - Asserting rst mid-stream clears all outputs on the next edge.
6. Exhaustive (WIDTH=4): all 512 combinations of a, b, cin, compared against a reference model of a+b+cin and the overflow/zero formulas -> zero mismatches.
